spi_peripheral_responder: RTL and testbench
===========================================

// Module: spi_peripheral_responder
// PURPOSE
//   SPI mode-0 target (CPOL=0, CPHA=0, MSB first): the responder end of the sck_o/cs_o/pico_o/poci_i controller port.
//   Oversamples SCK/CS/PICO in the single system clock domain; receives and transmits DATA_WIDTH-bit words.
//   Parallel side is a byte stream to/from user logic. Used as an on-board loopback target and as a bench model.
// PARAMETERS
//   DATA_WIDTH    8      bits per SPI word
//   SYNC_STAGES   2      flops per input synchronizer (>=2)
//   IDLE_WORD     'hFF   word shifted out on TX underrun
//   TX_FIFO_DEPTH 4      TX FIFO entries, power of 2 (used only with SPI_RESP_TX_FIFO_EN)
// PORTS
//   clk         in   1           system clock; SCK must be <= clk/4
//   reset       in   1           synchronous, active-high reset
//   sck_i       in   1           SPI clock from controller (async)
//   cs_i        in   1           chip select, active low (async)
//   pico_i      in   1           controller-out data (async)
//   poci_o      out  1           target-out data
//   poci_oe_o   out  1           POCI drive enable (tristate at pad)
//   rx_data_o   out  DATA_WIDTH  last complete received word
//   rx_valid_o  out  1           1-cycle pulse: rx_data_o updated
//   tx_data_i   in   DATA_WIDTH  next word to send
//   tx_valid_i  in   1           tx_data_i valid
//   tx_ready_o  out  1           TX store can accept; write = valid & ready
//   underrun_o  out  1           1-cycle pulse: IDLE_WORD loaded (TX store empty)
//   abort_o     out  1           1-cycle pulse: CS released mid-word
// BEHAVIOUR
//   Reset: poci_o=1, poci_oe_o=0, rx_data_o=0, rx_valid_o=0, tx_ready_o=1, underrun_o=0, abort_o=0; state IDLE; TX store emptied.
//   Inputs pass through SYNC_STAGES flops. Edges come from the last stage versus one extra registered copy.
//   FSM IDLE -> SHIFT on synced CS fall. SHIFT -> IDLE on synced CS rise. No other states.
//   CS fall:
//     - bit_cnt=0, rx shift cleared.
//     - Load tx shift from TX store head (pop). If the store is empty, load IDLE_WORD and pulse underrun_o.
//     - poci_o = MSB of the loaded word; poci_oe_o=1 while in SHIFT.
//   SCK rise (SHIFT):
//     - Shift synced pico into rx LSB; bit_cnt++.
//     - On the DATA_WIDTH-th rise: rx_data_o <= assembled word and rx_valid_o=1 on the following clk cycle. bit_cnt wraps to 0.
//   SCK fall (SHIFT):
//     - If bit_cnt!=0: shift tx left and drive the next MSB.
//     - If bit_cnt==0 (word boundary): load the next word (pop or IDLE_WORD+underrun) and drive its MSB.
//   CS rise with bit_cnt!=0:
//     - Partial rx discarded, no rx_valid_o, abort_o pulse.
//     - The popped TX word is lost, not resent.
//   CS rise with bit_cnt==0: clean end, no pulse. In IDLE: poci_oe_o=0, poci_o=1.
//   SCK edges while in IDLE are ignored. CS fall and SCK edge in the same cycle: CS handled, SCK edge ignored.
//   TX push and pop in the same cycle: pop sees the pre-push contents.
//     - An empty store yields IDLE_WORD; the pushed word stays for the next load.
//   Latency: pin SCK rise -> rx_valid_o = SYNC_STAGES+2 clk.
//   No back-pressure on RX: rx_data_o is overwritten by the next word.
// CONFIGURATION
//   SPI_RESP_TX_FIFO_EN defined:
//     - TX store is a TX_FIFO_DEPTH-entry FIFO.
//     - tx_ready_o = !full. Full + push = ignored; full + pop + push = accepted.
//   Not defined:
//     - TX store is a single holding register; tx_ready_o = empty.
//     - TX_FIFO_DEPTH is unused.
// STRUCTURE
//   spi_resp_pkg: FSM state enum (IDLE, SHIFT) and default IDLE_WORD.
//   Sub-module spi_resp_sync: SYNC_STAGES synchronizer plus rise/fall detect, with parameter SYNC_STAGES.
//     - Instantiated for sck_i and cs_i. pico_i uses the synchronizer only.
// TESTING
//   1 Push 'hA5, CS low, 8 clocks of PICO 'h3C at clk/8
//     -> POCI bits 1,0,1,0,0,1,0,1; rx_data_o='h3C with one rx_valid_o pulse.
//   2 Empty store, 16 SCK in one CS
//     -> underrun_o pulses twice; POCI='hFF,'hFF; two rx_valid_o pulses.
//   3 Push 'h11,'h22 (FIFO build), 16 SCK
//     -> POCI='h11 then 'h22; with FIFO off, 2nd push stalls (tx_ready_o=0) until CS fall.
//   4 CS rise after 5 SCK
//     -> abort_o pulse, no rx_valid_o; next transaction starts at bit 7 with the next word.
//   5 reset asserted mid-word
//     -> next cycle all outputs at reset values, store empty; SCK ignored until a new CS fall.
//   6 Push coincident with CS fall on an empty store
//     -> IDLE_WORD sent first, pushed word sent second.

Source files
------------

// File: rtl/spi_resp_pkg.sv
// Shared types for the SPI mode-0 responder: FSM state encoding and the default underrun word.
package spi_resp_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } spi_state_e;

    localparam logic [7:0] IDLE_WORD_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_peripheral_responder_if.sv
// Parallel byte-stream side of the SPI responder: RX word output, TX word input, status pulses.
interface spi_peripheral_responder_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] rx_data_o;
    logic                  rx_valid_o;
    logic [DATA_WIDTH-1:0] tx_data_i;
    logic                  tx_valid_i;
    logic                  tx_ready_o;
    logic                  underrun_o;
    logic                  abort_o;

    modport slave (
        output rx_data_o, rx_valid_o, tx_ready_o, underrun_o, abort_o,
        input  tx_data_i, tx_valid_i
    );

    modport master (
        input  rx_data_o, rx_valid_o, tx_ready_o, underrun_o, abort_o,
        output tx_data_i, tx_valid_i
    );

endinterface

// File: rtl/spi_resp_sync.sv
// Multi-flop input synchronizer with rise/fall detection against one extra registered copy.
module spi_resp_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stage_q;
    logic                   prev_q;

    // Chain resets low so a CS held low through reset does not look like a fresh falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], din};
            prev_q  <= stage_q[SYNC_STAGES-1];
        end
    end

    assign dout = stage_q[SYNC_STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_peripheral_responder.sv
// SPI mode-0 target, oversampled in the system clock domain. Define SPI_RESP_TX_FIFO_EN to
// replace the single TX holding register with a TX_FIFO_DEPTH-entry FIFO.
module spi_peripheral_responder
    import spi_resp_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH    = 8,
    parameter int unsigned           SYNC_STAGES   = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD     = DATA_WIDTH'(IDLE_WORD_DEFAULT),
    parameter int unsigned           TX_FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sck_i,
    input  logic                          cs_i,
    input  logic                          pico_i,
    output logic                          poci_o,
    output logic                          poci_oe_o,
    spi_peripheral_responder_if.slave     user
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);

    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;
    logic pico_s, pico_rise_unused, pico_fall_unused;

    spi_resp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .reset(reset), .din(sck_i), .dout(sck_s), .rise(sck_rise), .fall(sck_fall)
    );
    spi_resp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .reset(reset), .din(cs_i), .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );
    spi_resp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pico (
        .clk(clk), .reset(reset), .din(pico_i), .dout(pico_s),
        .rise(pico_rise_unused), .fall(pico_fall_unused)
    );

    logic                  pop;
    logic                  pop_take;
    logic                  push;
    logic                  store_empty;
    logic [DATA_WIDTH-1:0] store_head;

    assign pop_take = pop & ~store_empty;
    assign push     = user.tx_valid_i & user.tx_ready_o;

`ifdef SPI_RESP_TX_FIFO_EN
    localparam int unsigned PtrW = $clog2(TX_FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] fifo_mem [TX_FIFO_DEPTH];
    logic [PtrW-1:0]       wr_idx_q, rd_idx_q;
    logic [PtrW:0]         count_q;

    assign store_empty     = (count_q == '0);
    assign store_head      = fifo_mem[rd_idx_q];
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign user.tx_ready_o = (count_q != (PtrW+1)'(TX_FIFO_DEPTH)) | pop_take;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_idx_q] <= user.tx_data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)     wr_idx_q <= wr_idx_q + PtrW'(1);
            if (pop_take) rd_idx_q <= rd_idx_q + PtrW'(1);
            unique case ({push, pop_take})
                2'b10:   count_q <= count_q + (PtrW+1)'(1);
                2'b01:   count_q <= count_q - (PtrW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
`else
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_valid_q;

    assign store_empty     = ~hold_valid_q;
    assign store_head      = hold_q;
    assign user.tx_ready_o = ~hold_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
        end else begin
            hold_valid_q <= (hold_valid_q & ~pop) | push;
        end
        if (push) hold_q <= user.tx_data_i;
    end
`endif

    spi_state_e            state_q, state_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  rx_done_q, rx_done_d;
    logic                  underrun_q, underrun_d;
    logic                  abort_q, abort_d;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic [DATA_WIDTH-1:0] load_word;

    assign load_word = store_empty ? IDLE_WORD : store_head;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_done_d  = 1'b0;
        underrun_d = 1'b0;
        abort_d    = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d    = StShift;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    tx_shift_d = load_word;
                    underrun_d = store_empty;
                    pop        = 1'b1;
                end
            end
            StShift: begin
                // CS release wins over any SCK edge seen in the same cycle.
                if (cs_rise) begin
                    state_d   = StIdle;
                    abort_d   = (bit_cnt_q != '0);
                    bit_cnt_d = '0;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], pico_s};
                    if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        rx_done_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        tx_shift_d = load_word;
                        underrun_d = store_empty;
                        pop        = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_done_q  <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rx_done_q  <= rx_done_d;
            underrun_q <= underrun_d;
            abort_q    <= abort_d;
            rx_valid_q <= rx_done_q;
            if (rx_done_q) rx_data_q <= rx_shift_q;
        end
    end

    assign poci_o          = (state_q == StShift) ? tx_shift_q[DATA_WIDTH-1] : 1'b1;
    assign poci_oe_o       = (state_q == StShift);
    assign user.rx_data_o  = rx_data_q;
    assign user.rx_valid_o = rx_valid_q;
    assign user.underrun_o = underrun_q;
    assign user.abort_o    = abort_q;

endmodule

// File: tb/tb_spi_peripheral_responder.sv
// Randomized bench for the SPI responder: an SPI controller model drives SCK at clk/8 and
// checks POCI bits, RX words and status pulses against a queue-based reference.
module tb_spi_peripheral_responder;

    localparam int unsigned W        = 8;
    localparam logic [7:0]  IdleWord = 8'hFF;
`ifdef SPI_RESP_TX_FIFO_EN
    localparam int Cap = 4;
`else
    localparam int Cap = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sck = 1'b0;
    logic cs = 1'b1;
    logic pico = 1'b0;
    logic poci, poci_oe;

    spi_peripheral_responder_if #(.DATA_WIDTH(W)) user ();

    spi_peripheral_responder #(
        .DATA_WIDTH(W), .SYNC_STAGES(2), .IDLE_WORD(8'hFF), .TX_FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .sck_i(sck), .cs_i(cs), .pico_i(pico),
        .poci_o(poci), .poci_oe_o(poci_oe), .user(user.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Reference state: TX store contents, expected RX words and pulse counts.
    logic [7:0] model_q[$];
    logic [7:0] exp_rx[$];
    int e_under = 0, e_abort = 0, e_rxv = 0;
    int n_under = 0, n_abort = 0, n_rxv = 0;

    always @(negedge clk) begin
        if (user.underrun_o) n_under++;
        if (user.abort_o) n_abort++;
        if (user.rx_valid_o) begin
            n_rxv++;
            if (exp_rx.size() == 0) check_val("rx_unexpected", {31'd0, user.rx_valid_o}, 0);
            else check_val("rx_data", {24'd0, user.rx_data_o}, {24'd0, exp_rx.pop_front()});
        end
    end

    task automatic load_model(output logic [7:0] w);
        if (model_q.size() > 0) w = model_q.pop_front();
        else begin
            w = IdleWord;
            e_under++;
        end
    endtask

    // Caller is at a negedge; returns at a negedge after the word is accepted.
    task automatic push(input logic [7:0] w);
        int t = 0;
        user.tx_data_i  = w;
        user.tx_valid_i = 1'b1;
        while (!user.tx_ready_o && t < 400) begin
            @(negedge clk);
            t++;
        end
        check_val("push_accept", {31'd0, user.tx_ready_o}, 1);
        if (user.tx_ready_o) model_q.push_back(w);
        @(negedge clk);
        user.tx_valid_i = 1'b0;
    endtask

    // n SCK pulses in one CS window; the last SCK fall coincides with CS release.
    task automatic xfer(input int n, input logic [31:0] pd);
        logic [7:0] cur;
        int b;
        @(negedge clk);
        cs = 1'b0;
        load_model(cur);
        for (int k = 1; k <= n; k++) begin
            pico = pd[n-k];
            repeat (4) @(negedge clk);
            b = (k - 1) % W;
            check_val("poci_oe", {31'd0, poci_oe}, 1);
            check_val($sformatf("poci_bit%0d", 7 - b), {31'd0, poci}, {31'd0, cur[7-b]});
            sck = 1'b1;
            if (k % W == 0) begin
                exp_rx.push_back(pd[n-k +: 8]);
                e_rxv++;
            end
            for (int i = 1; i <= 4; i++) begin
                @(negedge clk);
                if (k % W == 0 && i >= 3)
                    check_val("rx_latency", {31'd0, user.rx_valid_o}, (i == 4) ? 1 : 0);
            end
            sck = 1'b0;
            if (k == n) cs = 1'b1;
            else if (k % W == 0) load_model(cur);
        end
        if (n % W != 0) e_abort++;
        repeat (8) @(negedge clk);
        check_val("poci_oe_idle", {31'd0, poci_oe}, 0);
        check_val("poci_idle", {31'd0, poci}, 1);
    endtask

    task automatic check_counts(input string tag);
        check_val({tag, "_underruns"}, n_under, e_under);
        check_val({tag, "_aborts"}, n_abort, e_abort);
        check_val({tag, "_rx_valids"}, n_rxv, e_rxv);
        check_val({tag, "_rx_pending"}, exp_rx.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_poci"}, {31'd0, poci}, 1);
        check_val({tag, "_poci_oe"}, {31'd0, poci_oe}, 0);
        check_val({tag, "_rx_data"}, {24'd0, user.rx_data_o}, 0);
        check_val({tag, "_rx_valid"}, {31'd0, user.rx_valid_o}, 0);
        check_val({tag, "_tx_ready"}, {31'd0, user.tx_ready_o}, 1);
        check_val({tag, "_underrun"}, {31'd0, user.underrun_o}, 0);
        check_val({tag, "_abort"}, {31'd0, user.abort_o}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [7:0] dummy;
        int n, np;
        user.tx_valid_i = 1'b0;
        user.tx_data_i  = '0;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single word, A5 out, 3C in
        push(8'hA5);
        xfer(8, 32'h3C);
        check_counts("t1");

        // 2: empty store across two words
        xfer(16, 32'hC3_96);
        check_counts("t2");

        // 3: two queued words; single-register store stalls the second push until CS fall
        push(8'h11);
        check_val("t3_tx_ready", {31'd0, user.tx_ready_o}, (model_q.size() < Cap) ? 1 : 0);
        fork
            push(8'h22);
            xfer(16, 32'h5A_0F);
        join
        check_counts("t3");

        // 4: CS released after 5 SCK, next transfer starts with the next word
        push(8'h66);
        xfer(5, 32'h15);
        check_counts("t4a");
        push(8'h77);
        xfer(8, 32'hE1);
        check_counts("t4b");

        // 5: reset mid-word empties the store and ignores SCK until a new CS fall
        @(negedge clk);
        cs = 1'b0;
        load_model(dummy);
        repeat (4) @(negedge clk);
        push(8'h99);
        for (int k = 0; k < 3; k++) begin
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("t5");
        model_q.delete();
        repeat (4) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            sck = 1'b1;
            repeat (4) @(negedge clk);
            check_val("t5_oe_ignored", {31'd0, poci_oe}, 0);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        cs = 1'b1;
        repeat (8) @(negedge clk);
        check_counts("t5");
        xfer(8, 32'hA7);
        check_counts("t5_after");

        // 6: push lands in the same cycle as the CS-fall pop on an empty store
        fork
            begin
                repeat (3) @(negedge clk);
                push(8'h5A);
            end
            xfer(16, 32'h3C_C3);
        join
        check_counts("t6");

        // Randomized transfers
        for (int it = 0; it < 20; it++) begin
            np = $urandom_range(Cap - model_q.size(), 0);
            for (int p = 0; p < np; p++) push(8'($urandom));
            check_val("rnd_tx_ready", {31'd0, user.tx_ready_o}, (model_q.size() < Cap) ? 1 : 0);
            case ($urandom_range(2, 0))
                0:       n = 8;
                1:       n = 16;
                default: n = $urandom_range(20, 1);
            endcase
            xfer(n, $urandom);
            check_counts($sformatf("rnd%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
